vehicle_mux_sequencer: RTL and testbench

Sequencer that drives the 2-bit select bus of the 4:1 vehicle-pattern multiplexers in each traffic lane. It rotates the select round-robin over the enabled pattern sources and holds each source for a programmable number of game-speed ticks. Disabled sources are skipped. Start/stop control comes from the game FSM.

---
 rtl/vehicle_mux_sequencer.sv | 120 ++++++++++++
 tb/tb_vehicle_mux_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vehicle_mux_sequencer.sv
// Round-robin select sequencer for the lane 4:1 vehicle-pattern muxes.
// Holds each enabled source for a programmable number of game ticks and skips disabled sources.
module vehicle_mux_sequencer #(
  parameter int DATAWIDTH_SELECTOR = 2,
  parameter int DATAWIDTH_DWELL    = 8
) (
  input  logic                          VEHICLE_SEQ_CLOCK_50,
  input  logic                          VEHICLE_SEQ_RESET_InHigh,
  input  logic                          VEHICLE_SEQ_START_In,
  input  logic                          VEHICLE_SEQ_STOP_In,
  input  logic                          VEHICLE_SEQ_TICK_In,
  input  logic [3:0]                    VEHICLE_SEQ_MASK_In,
  input  logic [DATAWIDTH_DWELL-1:0]    VEHICLE_SEQ_DWELL_In,
  output logic [DATAWIDTH_SELECTOR-1:0] VEHICLE_SEQ_SELECT_Out,
  output logic                          VEHICLE_SEQ_VALID_Out,
  output logic                          VEHICLE_SEQ_CHANGE_Out,
  output logic                          VEHICLE_SEQ_BUSY_Out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  logic [1:0]                 state;
  logic [DATAWIDTH_DWELL-1:0] dwell_cnt;
  logic [DATAWIDTH_DWELL-1:0] dwell_load;
  logic [1:0]                 first_sel;
  logic [1:0]                 next_sel;
  logic                       mask_any;
  logic                       cur_enabled;

  // First enabled source after cur, wrapping round to cur itself last.
  function automatic logic [1:0] next_idx(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] idx;
    next_idx = cur;
    for (int k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (m[idx]) next_idx = idx;
    end
  endfunction

  function automatic logic [1:0] first_idx(input logic [3:0] m);
    first_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) first_idx = 2'(k);
    end
  endfunction

  assign mask_any    = |VEHICLE_SEQ_MASK_In;
  assign first_sel   = first_idx(VEHICLE_SEQ_MASK_In);
  assign next_sel    = next_idx(VEHICLE_SEQ_SELECT_Out, VEHICLE_SEQ_MASK_In);
  assign cur_enabled = VEHICLE_SEQ_MASK_In[VEHICLE_SEQ_SELECT_Out];
  // A zero dwell would never expire, so it is promoted to one tick.
  assign dwell_load  = (VEHICLE_SEQ_DWELL_In == '0) ? DATAWIDTH_DWELL'(1) : VEHICLE_SEQ_DWELL_In;

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge VEHICLE_SEQ_CLOCK_50) begin
    if (VEHICLE_SEQ_RESET_InHigh) begin
      state                  <= ST_IDLE;
      dwell_cnt              <= '0;
      VEHICLE_SEQ_SELECT_Out <= '0;
      VEHICLE_SEQ_VALID_Out  <= 1'b0;
      VEHICLE_SEQ_CHANGE_Out <= 1'b0;
      VEHICLE_SEQ_BUSY_Out   <= 1'b0;
    end else begin
      VEHICLE_SEQ_CHANGE_Out <= 1'b0;
      if (VEHICLE_SEQ_STOP_In) begin
        state                  <= ST_IDLE;
        dwell_cnt              <= '0;
        VEHICLE_SEQ_SELECT_Out <= '0;
        VEHICLE_SEQ_VALID_Out  <= 1'b0;
        VEHICLE_SEQ_BUSY_Out   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (VEHICLE_SEQ_START_In && mask_any) begin
              state                  <= ST_RUN;
              dwell_cnt              <= dwell_load;
              VEHICLE_SEQ_SELECT_Out <= first_sel;
              VEHICLE_SEQ_VALID_Out  <= 1'b1;
              VEHICLE_SEQ_CHANGE_Out <= 1'b1;
              VEHICLE_SEQ_BUSY_Out   <= 1'b1;
            end
          end
          ST_RUN: begin
            if (!mask_any) begin
              state                 <= ST_STALL;
              VEHICLE_SEQ_VALID_Out <= 1'b0;
            end else if (VEHICLE_SEQ_TICK_In) begin
              // A source masked off mid-dwell is abandoned at the first tick.
              if (dwell_cnt <= DATAWIDTH_DWELL'(1) || !cur_enabled) begin
                dwell_cnt              <= dwell_load;
                VEHICLE_SEQ_SELECT_Out <= next_sel;
                VEHICLE_SEQ_CHANGE_Out <= (next_sel != VEHICLE_SEQ_SELECT_Out);
              end else begin
                dwell_cnt <= dwell_cnt - DATAWIDTH_DWELL'(1);
              end
            end
          end
          ST_STALL: begin
            if (mask_any) begin
              state                  <= ST_RUN;
              dwell_cnt              <= dwell_load;
              VEHICLE_SEQ_SELECT_Out <= next_sel;
              VEHICLE_SEQ_VALID_Out  <= 1'b1;
              VEHICLE_SEQ_CHANGE_Out <= 1'b1;
            end
          end
          default: begin
            state                  <= ST_IDLE;
            VEHICLE_SEQ_SELECT_Out <= '0;
            VEHICLE_SEQ_VALID_Out  <= 1'b0;
            VEHICLE_SEQ_BUSY_Out   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vehicle_mux_sequencer.sv
// Scoreboard bench for vehicle_mux_sequencer: directed scenarios then random stimulus,
// checked against a behavioural model of the rotation rules.
module tb_vehicle_mux_sequencer;

  typedef struct packed {
    logic [1:0] sel;
    logic       valid;
    logic       change;
    logic       busy;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst, start, stop, tick;
  logic [3:0] mask;
  logic [7:0] dwell;
  logic [1:0] sel_o;
  logic       valid_o, change_o, busy_o;

  obs_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Behavioural model state
  int   m_mode = 0;      // 0 idle, 1 running, 2 stalled
  int   m_sel = 0;
  int   m_left = 0;      // ticks remaining on current source
  bit   m_valid = 0, m_busy = 0;

  vehicle_mux_sequencer #(.DATAWIDTH_SELECTOR(2), .DATAWIDTH_DWELL(8)) dut (
    .VEHICLE_SEQ_CLOCK_50    (clk),
    .VEHICLE_SEQ_RESET_InHigh(rst),
    .VEHICLE_SEQ_START_In    (start),
    .VEHICLE_SEQ_STOP_In     (stop),
    .VEHICLE_SEQ_TICK_In     (tick),
    .VEHICLE_SEQ_MASK_In     (mask),
    .VEHICLE_SEQ_DWELL_In    (dwell),
    .VEHICLE_SEQ_SELECT_Out  (sel_o),
    .VEHICLE_SEQ_VALID_Out   (valid_o),
    .VEHICLE_SEQ_CHANGE_Out  (change_o),
    .VEHICLE_SEQ_BUSY_Out    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int rr_next(input int cur, input logic [3:0] m);
    for (int k = 1; k <= 4; k++)
      if (m[(cur + k) % 4]) return (cur + k) % 4;
    return cur;
  endfunction

  function automatic int lowest(input logic [3:0] m);
    for (int k = 0; k < 4; k++)
      if (m[k]) return k;
    return 0;
  endfunction

  // Advance the model by one clock edge for the given inputs; returns the expected outputs.
  function automatic obs_t model_step(input bit r, s, p, t, input logic [3:0] m, input int d);
    obs_t o;
    int   ld, n;
    bit   chg;
    ld  = (d == 0) ? 1 : d;
    chg = 0;
    if (r || p) begin
      m_mode = 0; m_sel = 0; m_left = 0; m_valid = 0; m_busy = 0;
    end else if (m_mode == 0) begin
      if (s && m != 0) begin
        m_mode = 1; m_sel = lowest(m); m_left = ld; m_valid = 1; m_busy = 1; chg = 1;
      end
    end else if (m_mode == 1) begin
      if (m == 0) begin
        m_mode = 2; m_valid = 0;
      end else if (t) begin
        if (m_left <= 1 || !m[m_sel]) begin
          n = rr_next(m_sel, m);
          chg = (n != m_sel);
          m_sel = n; m_left = ld;
        end else begin
          m_left = m_left - 1;
        end
      end
    end else begin
      if (m != 0) begin
        m_mode = 1; m_sel = rr_next(m_sel, m); m_left = ld; m_valid = 1; chg = 1;
      end
    end
    o.sel = 2'(m_sel); o.valid = m_valid; o.change = chg; o.busy = m_busy;
    return o;
  endfunction

  task automatic drive(input bit r, s, p, t, input logic [3:0] m, input logic [7:0] d);
    @(negedge clk);
    rst = r; start = s; stop = p; tick = t; mask = m; dwell = d;
    exp_q.push_back(model_step(r, s, p, t, m, int'(d)));
  endtask

  // Monitor: outputs are registered, so every edge presents a response to compare.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{sel: sel_o, valid: valid_o, change: change_o, busy: busy_o};
        check("outputs{sel,valid,change,busy}", 32'(a), 32'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; stop = 0; tick = 0; mask = 0; dwell = 0;
    repeat (3) drive(1, 0, 0, 0, 4'b0000, 8'd0);

    // Full rotation, dwell 3, tick every 4 clocks
    drive(0, 1, 0, 0, 4'b1111, 8'd3);
    for (int i = 0; i < 64; i++) drive(0, 0, 0, (i % 4) == 3, 4'b1111, 8'd3);
    drive(0, 0, 1, 0, 4'b1111, 8'd3);

    // Sources 1 and 3 only, wrap 3 -> 1
    drive(0, 1, 0, 0, 4'b1010, 8'd2);
    for (int i = 0; i < 30; i++) drive(0, 0, 0, i[0], 4'b1010, 8'd2);
    drive(0, 0, 1, 0, 4'b1010, 8'd2);

    // Dwell 5, reach source 2 then mask it off mid-dwell
    drive(0, 1, 0, 0, 4'b1111, 8'd5);
    for (int i = 0; i < 11; i++) drive(0, 0, 0, 1, 4'b1111, 8'd5);
    drive(0, 0, 0, 0, 4'b1011, 8'd5);
    drive(0, 0, 0, 0, 4'b1011, 8'd5);
    drive(0, 0, 0, 1, 4'b1011, 8'd5);
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 1, 4'b1011, 8'd5);

    // Stall on empty mask, resume without tick
    drive(0, 0, 0, 0, 4'b0000, 8'd5);
    drive(0, 0, 0, 1, 4'b0000, 8'd5);
    drive(0, 0, 0, 0, 4'b0001, 8'd5);
    drive(0, 0, 0, 0, 4'b0001, 8'd5);

    // START+STOP together, STOP during RUN, START with empty mask
    drive(0, 0, 1, 0, 4'b0001, 8'd5);
    drive(0, 1, 1, 0, 4'b1111, 8'd1);
    drive(0, 1, 0, 0, 4'b0000, 8'd1);
    drive(0, 0, 0, 0, 4'b0000, 8'd1);

    // Single source, dwell 0, tick every cycle, then reset mid-run
    drive(0, 1, 0, 0, 4'b0100, 8'd0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 4'b0100, 8'd0);
    drive(1, 0, 0, 1, 4'b0100, 8'd0);
    drive(0, 0, 0, 0, 4'b0100, 8'd0);

    // DWELL changes mid-dwell only apply at reload
    drive(0, 1, 0, 0, 4'b0011, 8'd4);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 1, 4'b0011, 8'(1 + (i % 3)));

    // Randomized phase
    begin
      logic [3:0] rm;
      logic [7:0] rd;
      rm = 4'b1111; rd = 8'd2;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 19) == 0) rm = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0)  rd = 8'($urandom_range(0, 4));
        drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, rm, rd);
      end
    end

    drive(0, 0, 0, 0, 4'b0000, 8'd0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
